// File: rtl/param_matrix_mac_engine.sv
// param_matrix_mac_engine: serial N x N matrix multiplier, C = A * B.
// One shared multiply-accumulate unit performs one product per cycle, so a full
// product takes exactly N^3 cycles. The operands are captured when start is
// accepted, and the caller may change them afterwards.
// Optional build macro PMM_SATURATE_EN: the accumulator is widened so it cannot
// overflow, and each C element is clamped to the ACC_W range when it is written.
// Without the macro, results wrap modulo 2^ACC_W.
module param_matrix_mac_engine #(
  parameter int N      = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [N*N*DATA_W-1:0]   a_flat,
  input  logic [N*N*DATA_W-1:0]   b_flat,
  output logic [N*N*ACC_W-1:0]    c_flat,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W  = $clog2(N);
  localparam int PROD_W = 2 * DATA_W;
`ifdef PMM_SATURATE_EN
  localparam int ACC_INT_W = 2 * DATA_W + $clog2(N) + 1;
`else
  localparam int ACC_INT_W = ACC_W;
`endif

  // Reject configurations the datapath cannot represent.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("param_matrix_mac_engine: N must be in 2..8");
  end
  if (ACC_W < 2 * DATA_W) begin : g_bad_acc
    $error("param_matrix_mac_engine: ACC_W must be >= 2*DATA_W");
  end

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [N*N*DATA_W-1:0]   a_q, b_q;
  logic [IDX_W-1:0]        i_q, j_q, k_q;
  logic [ACC_INT_W-1:0]    acc_q;
  logic [DATA_W-1:0]       a_el, b_el;
  logic [PROD_W-1:0]       a_x, b_x, prod;
  logic [ACC_INT_W-1:0]    prod_x, sum;
  logic [ACC_W-1:0]        c_val;
  logic                    last_k, last_j, last_i, last_all;

  assign last_k   = (k_q == IDX_W'(N - 1));
  assign last_j   = (j_q == IDX_W'(N - 1));
  assign last_i   = (i_q == IDX_W'(N - 1));
  assign last_all = last_k && last_j && last_i;

  // Select A[i][k] and B[k][j], multiply them at full width, and add the product to acc.
  always_comb begin
    a_el = a_q[(int'(i_q) * N + int'(k_q)) * DATA_W +: DATA_W];
    b_el = b_q[(int'(k_q) * N + int'(j_q)) * DATA_W +: DATA_W];
    // Extending both operands to PROD_W first means the low PROD_W bits of the
    // plain multiply are the correct signed or unsigned product.
    if (SIGNED != 0) begin
      a_x    = PROD_W'($signed(a_el));
      b_x    = PROD_W'($signed(b_el));
    end else begin
      a_x    = PROD_W'(a_el);
      b_x    = PROD_W'(b_el);
    end
    prod = a_x * b_x;
    if (SIGNED != 0) prod_x = ACC_INT_W'($signed(prod));
    else             prod_x = ACC_INT_W'(prod);
    sum = acc_q + prod_x;
  end

`ifdef PMM_SATURATE_EN
  // One spare bit above both widths, so the range limits and comparisons never overflow.
  localparam int EXT_W = ((ACC_INT_W > ACC_W) ? ACC_INT_W : ACC_W) + 1;
  localparam logic [EXT_W-1:0] S_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic [EXT_W-1:0] S_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [EXT_W-1:0] U_MAX = {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  logic [EXT_W-1:0] sum_x;

  // Clamp the exact dot product to the range of a C element.
  always_comb begin
    if (SIGNED != 0) sum_x = EXT_W'($signed(sum));
    else             sum_x = EXT_W'(sum);
    c_val = sum_x[ACC_W-1:0];
    if (SIGNED != 0) begin
      if ($signed(sum_x) > $signed(S_MAX))      c_val = S_MAX[ACC_W-1:0];
      else if ($signed(sum_x) < $signed(S_MIN)) c_val = S_MIN[ACC_W-1:0];
    end else if (sum_x > U_MAX) begin
      c_val = U_MAX[ACC_W-1:0];
    end
  end
`else
  assign c_val = sum;
`endif

  // State register.
  // NOTE: every clocked block uses non-blocking assignments, so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: IDLE -> MAC on start; MAC -> IDLE after the last product.
  // NOTE: state_nxt gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)    state_nxt = MAC;
      MAC:  if (last_all) state_nxt = IDLE;
    endcase
  end

  // Datapath: capture the operands, step i/j/k in row-major order, and write each C element.
  // NOTE: the operand snapshot and c_flat are plain flops, not a RAM, so they clear on reset like everything else.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      c_flat <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_flat;
            b_q   <= b_flat;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          if (last_k) begin
            // The final product goes straight into C, so no separate write-back cycle is needed.
            c_flat[(int'(i_q) * N + int'(j_q)) * ACC_W +: ACC_W] <= c_val;
            acc_q <= '0;
            k_q   <= '0;
            if (last_j) begin
              j_q <= '0;
              i_q <= last_i ? '0 : i_q + IDX_W'(1);
            end else begin
              j_q <= j_q + IDX_W'(1);
            end
            if (last_all) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end else begin
            acc_q <= sum;
            k_q   <= k_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

endmodule
